mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port unified memory between the CPU datapath and the UART debug/loader port.
- Each requester uses a req/ack handshake.
- Supports a debug lock that excludes the CPU so the host can load or inspect memory while the core is frozen.
- Sits between the CPU, the UART command block and the memory macro. It replaces the direct override mux.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- RD_LATENCY, 1, cycles from the edge sampling mem_en to the edge where mem_rdata is valid. Legal range 1..7.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_rnw  in  1  1 = read, 0 = write.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  read data; valid with cpu_ack and held until the next CPU read ack.
- dbg_req, dbg_rnw, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same as the CPU port, for the UART side.
- dbg_lock  in  1  level; while high the CPU is never granted.
- dbg_locked  out  1  high when dbg_lock is high and no CPU access is in flight.
- mem_en  out  1  memory strobe, one cycle per access.
- mem_rnw  out  1  memory read/write select.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
Reset:
- All outputs are registered.
- rst_n low asynchronously forces:
  - state IDLE;
  - mem_en, mem_rnw, cpu_ack, dbg_ack, dbg_locked = 0;
  - mem_addr, mem_wdata, cpu_rdata, dbg_rdata = 0;
  - rr_ptr = DBG;
  - wait counter = 0.
- Reset mid-access aborts the access; mem_en drops immediately and no ack is issued.

States:
- IDLE.
- ISSUE: mem_en = 1 for exactly one cycle; mem_addr/mem_rnw/mem_wdata hold the latched request.
- WAIT: 3-bit counter runs 1..RD_LATENCY; mem_en = 0.
- DONE: single cycle.

Transitions and timing:
- IDLE -> ISSUE at edge N when an eligible request exists; the grant target and request fields are latched at N.
- ISSUE -> WAIT at N+1.
- WAIT -> DONE on the edge where count == RD_LATENCY, i.e. edge N+1+RD_LATENCY.
  - For reads, mem_rdata is captured into the granted port's rdata register at this edge.
  - The granted port's ack goes high for that cycle.
- DONE -> IDLE at the next edge; ack returns to 0.
- Writes follow identical timing; rdata is unchanged on write acks.
- Requester sees ack 1+RD_LATENCY cycles after mem_en.
- Throughput is one access per 3+RD_LATENCY cycles.

Eligibility:
- A requester is eligible in IDLE if its req = 1.
- The CPU is additionally ineligible while dbg_lock = 1.
- A requester whose ack was high in the previous cycle is not re-granted in the cycle its req is dropping. The DONE state guarantees this.

Arbitration:
- Only one requester eligible: grant it.
- Both eligible: grant the side opposite rr_ptr's last grant. rr_ptr updates on every grant.
- After reset with both eligible, the CPU wins first, because rr_ptr = DBG marks debug as last granted.

Lock:
- dbg_lock rising during a CPU access does not abort that access.
- dbg_locked rises in the cycle after state is IDLE or a debug access with dbg_lock = 1.
- dbg_locked falls one cycle after dbg_lock falls.
- dbg_lock falling re-enables CPU eligibility from the next IDLE sample.

Other rules:
- Request fields are sampled only at the grant edge; changes afterwards are ignored.
- A req with no ack outstanding stays pending indefinitely; there is no timeout.

Test Plan:
1. RD_LATENCY = 1, memory preloaded with 0x1234 at 0x0040, CPU read of 0x0040 alone -> mem_en one cycle after grant; cpu_ack 2 cycles after mem_en's edge; cpu_rdata = 0x1234; dbg_ack stays 0.
2. dbg write 0xBEEF to 0x0100, then dbg read of 0x0100 -> mem_en/rnw = 0/wdata 0xBEEF once; read returns 0xBEEF; no duplicate grant while req is dropping.
3. cpu_req and dbg_req both held continuously after reset -> grants alternate CPU, DBG, CPU, DBG; each ack is a one-cycle pulse 4 cycles apart for RD_LATENCY = 1.
4. CPU read in flight, dbg_lock raised at ISSUE -> CPU access completes with ack; dbg_locked rises after DONE; a held cpu_req receives no grant while locked; dbg accesses proceed back-to-back.
5. dbg_lock dropped with cpu_req pending -> dbg_locked falls next cycle; CPU granted at the next IDLE sample.
6. rst_n pulsed low during WAIT of a CPU read -> mem_en, cpu_ack, cpu_rdata = 0 immediately; after release, the still-held cpu_req is granted as a fresh access.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU and the UART debug port.
// One access at a time: IDLE -> ISSUE (strobe) -> WAIT (read latency) -> DONE (ack).
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_rnw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_rnw,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_lock,
  output logic              dbg_locked,
  output logic              mem_en,
  output logic              mem_rnw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              gnt_dbg_q, gnt_dbg_d;
  logic              rr_dbg_q, rr_dbg_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_rnw_q, mem_rnw_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              dbg_locked_q, dbg_locked_d;
  logic              cpu_elig, dbg_elig, pick_dbg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      gnt_dbg_q    <= 1'b0;
      rr_dbg_q     <= 1'b1;
      mem_en_q     <= 1'b0;
      mem_rnw_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      dbg_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      dbg_locked_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_dbg_q    <= gnt_dbg_d;
      rr_dbg_q     <= rr_dbg_d;
      mem_en_q     <= mem_en_d;
      mem_rnw_q    <= mem_rnw_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_ack_q    <= cpu_ack_d;
      dbg_ack_q    <= dbg_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_locked_q <= dbg_locked_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_dbg_d   = gnt_dbg_q;
    rr_dbg_d    = rr_dbg_q;
    mem_en_d    = 1'b0;
    mem_rnw_d   = mem_rnw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;

    cpu_elig = cpu_req & ~dbg_lock;
    dbg_elig = dbg_req;
    // On a tie the side that was not granted last wins.
    pick_dbg = dbg_elig & (~cpu_elig | ~rr_dbg_q);

    // Locked once the lock is requested and no CPU access remains in flight.
    dbg_locked_d = dbg_lock & ((state_q == IDLE) | gnt_dbg_q);

    case (state_q)
      IDLE: begin
        if (cpu_elig | dbg_elig) begin
          state_d     = ISSUE;
          gnt_dbg_d   = pick_dbg;
          rr_dbg_d    = pick_dbg;
          mem_en_d    = 1'b1;
          mem_rnw_d   = pick_dbg ? dbg_rnw   : cpu_rnw;
          mem_addr_d  = pick_dbg ? dbg_addr  : cpu_addr;
          mem_wdata_d = pick_dbg ? dbg_wdata : cpu_wdata;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = 3'd1;
      end
      WAIT: begin
        if (cnt_q == LAT) begin
          state_d = DONE;
          cnt_d   = 3'd0;
          if (gnt_dbg_q) begin
            dbg_ack_d = 1'b1;
            if (mem_rnw_q) dbg_rdata_d = mem_rdata;
          end else begin
            cpu_ack_d = 1'b1;
            if (mem_rnw_q) cpu_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DONE: begin
        // Extra cycle lets the acked requester drop req before the next IDLE sample.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_en     = mem_en_q;
  assign mem_rnw    = mem_rnw_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign dbg_ack    = dbg_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign dbg_locked = dbg_locked_q;

endmodule
